game_timer: RTL
===============

Name: game_timer

Overview:
Parametrised game countdown/count-up timer, the next generation of the fixed 5-bit game counter. It runs from the slow game clock and adds a run/pause/expire state machine, runtime loading, direction select, configurable step and saturation at the terminal value. It also provides optional auto-reload and a one-cycle terminal-count pulse. It feeds the score/display logic and the game-over control.

Parameters:
WIDTH, 5, counter width in bits; legal range 2..16.
INIT_VAL, 2**WIDTH-1, reset value of count_o and of the internal reload register.
STEP, 1, amount added or subtracted per counting edge; legal range 1..2**WIDTH-1.
AUTO_RELOAD, 0, 0 = stop in DONE at terminal; 1 = reload and keep running.

Ports:
clk_4_i  input  1  game clock; all logic on rising edge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  start request; sampled level
pause_i  input  1  hold request while running; sampled level
load_i  input  1  load request; sampled level
load_val_i  input  WIDTH  value for load; also captured as reload value
up_i  input  1  1 = count up, 0 = count down; sampled each counting edge
count_o  output  WIDTH  current count (registered)
state_o  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
running_o  output  1  1 when state_o==RUN
expired_o  output  1  1 when state_o==DONE
tick_o  output  1  one-cycle terminal-count pulse (registered)

Behaviour:
- Reset (rst_i=1 at an edge): count_o=INIT_VAL, reload_q=INIT_VAL, state IDLE, tick_o=0, expired_o=0. Reset overrides all other inputs.
- Per-edge priority: rst_i > load_i > start_i > pause_i > counting.
- Terminal value T: 0 when up_i=0; 2**WIDTH-1 when up_i=1.
- load_i=1 in any state:
  - count_o<=load_val_i, reload_q<=load_val_i, state<=IDLE, tick_o<=0.
  - start_i in the same cycle is ignored.
- IDLE:
  - start_i=1 and count_o!=T: state<=RUN; count unchanged on this edge.
  - start_i=1 and count_o==T: state<=DONE; tick_o<=1.
  - Otherwise hold.
- RUN:
  - pause_i=1: state<=PAUSE; no step on this edge.
  - Otherwise step count_o by STEP toward T. Arithmetic is done at WIDTH+1 bits and saturates at T: down gives max(count-STEP,0); up gives min(count+STEP,2**WIDTH-1).
  - If the new value equals T: tick_o<=1 on the same edge, then:
    - AUTO_RELOAD=0: state<=DONE.
    - AUTO_RELOAD=1: stay in RUN. On the next non-paused edge, count_o<=reload_q instead of stepping; tick_o is not asserted for that reload.
- PAUSE:
  - pause_i=0: state<=RUN; no step on this edge.
  - start_i is ignored; count holds.
- DONE:
  - count holds at T.
  - start_i=1: count_o<=reload_q, state<=RUN.
  - pause_i is ignored.
- tick_o is high for exactly one cycle per terminal arrival and 0 at all other times.
- up_i may change during RUN. The new direction applies from that edge, including which T is used.
- Latency: start/pause/resume acceptance takes 1 edge; the first step occurs on the edge after RUN is entered.

Test Plan:
1. WIDTH=5 defaults; reset, then start_i pulse, up_i=0:
   - count_o stays 31 on the start edge, then 30, 29, … down to 0.
   - tick_o is high exactly in the cycle count_o==0, state_o=11, expired_o=1.
   - count_o holds 0 for 10 further edges.
2. Pause while running at count_o=20:
   - pause_i high for 5 edges: count_o stays 20 and state_o=10.
   - After pause_i falls: one edge at 20 with state_o=01, then 19.
3. load_i=1 with load_val_i=7 and start_i=1 in the same cycle, while in RUN:
   - count_o=7, state_o=00, start ignored.
   - Next start_i then gives 7→6 after one edge.
4. STEP=3, up_i=1: load 26, start:
   - Sequence 26, 29, 31 (saturated).
   - tick_o high with count_o=31, state DONE.
   - start_i in DONE reloads 26 and state_o=01.
5. AUTO_RELOAD=1: load 2, start:
   - count_o sequence 2, 1, 0, 2, 1, 0, …
   - tick_o high only in the cycles where count_o==0; state_o stays 01.
6. Edge cases:
   - rst_i=1 at count_o=12 in RUN: next edge count_o=31, state_o=00, tick_o=0.
   - Separately, load 0 then start with up_i=0: immediate DONE with a single tick_o pulse.

Source files
------------

// File: rtl/game_timer.sv
// Game countdown/count-up timer with a run/pause/expire state machine,
// runtime load, direction select, saturating step and optional auto-reload.
module game_timer #(
  parameter int WIDTH       = 5,
  parameter int INIT_VAL    = 2**WIDTH-1,
  parameter int STEP        = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk_4_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o,
  output logic [1:0]       state_o,
  output logic             running_o,
  output logic             expired_o,
  output logic             tick_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INIT_W  = WIDTH'(INIT_VAL);
  localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] terminal, stepped;
  logic [WIDTH:0]   sum_up, diff_down;

  // Extra top bit flags overflow (up) or borrow (down), which selects saturation.
  always_comb begin
    terminal  = up_i ? MAX_VAL : '0;
    sum_up    = {1'b0, count_q} + STEP_W;
    diff_down = {1'b0, count_q} - STEP_W;
    if (up_i) stepped = sum_up[WIDTH] ? MAX_VAL : sum_up[WIDTH-1:0];
    else      stepped = diff_down[WIDTH] ? '0 : diff_down[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    pend_d   = pend_q;
    if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
      state_d  = IDLE;
      pend_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (count_q == terminal) begin
              state_d = DONE;
              tick_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (pause_i) begin
            state_d = PAUSE;
          end else if (pend_q) begin
            // Auto-reload edge after a terminal arrival: restore, no tick.
            count_d = reload_q;
            pend_d  = 1'b0;
          end else begin
            count_d = stepped;
            if (stepped == terminal) begin
              tick_d = 1'b1;
              if (AUTO_RELOAD) pend_d = 1'b1;
              else             state_d = DONE;
            end
          end
        end
        PAUSE: begin
          if (!pause_i) state_d = RUN;
        end
        DONE: begin
          if (start_i) begin
            count_d = reload_q;
            state_d = RUN;
            pend_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_4_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= INIT_W;
      reload_q <= INIT_W;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign state_o   = state_q;
  assign running_o = (state_q == RUN);
  assign expired_o = (state_q == DONE);
  assign tick_o    = tick_q;

endmodule
